// File: rtl/fs_nms_if.sv
// rtl/fs_nms_if.sv - pixel-in / result-out handshake bundle for the fs_nms stage
interface fs_nms_if #(
  parameter int XW = 6,
  parameter int YW = 6
);
  logic          inValid;
  logic          inReady;
  logic          inSof;
  logic          inCorner;
  logic [7:0]    inScore;
  logic          outValid;
  logic          outReady;
  logic          outCorner;
  logic [7:0]    outScore;
  logic [XW-1:0] outX;
  logic [YW-1:0] outY;
  logic          frameDone;

  modport master (
    output inValid, inSof, inCorner, inScore, outReady,
    input  inReady, outValid, outCorner, outScore, outX, outY, frameDone
  );

  modport slave (
    input  inValid, inSof, inCorner, inScore, outReady,
    output inReady, outValid, outCorner, outScore, outX, outY, frameDone
  );
endinterface

// File: rtl/fs_nms.sv
// rtl/fs_nms.sv - 3x3 non-maximum suppression over the FAST score raster stream
// Optional FS_NMS_TIEBREAK_EN: among equal adjacent maxima only the raster-first survives.
module fs_nms #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 48,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT)
) (
  input  logic   clk,
  input  logic   rst_n,
  fs_nms_if.slave s
);

  logic [XW-1:0] x_q, x_d, cx;
  logic [YW-1:0] y_q, y_d, cy;
  logic [7:0]    line1_q [WIDTH];
  logic [7:0]    line2_q [WIDTH];
  logic [7:0]    win_q [3][3];
  logic [7:0]    win_d [3][3];

  logic          out_valid_q, out_valid_d;
  logic          out_corner_q, out_corner_d;
  logic [7:0]    out_score_q, out_score_d;
  logic [XW-1:0] out_x_q, out_x_d;
  logic [YW-1:0] out_y_q, out_y_d;
  logic          frame_done_q, frame_done_d;

  logic          accept, produce, last_x, last_y, survive;
  logic [7:0]    s_eff, lb1_rd, lb2_rd;
  logic [7:0]    c, nw, n, ne, w, e, sw, so, se;

  assign s.inReady = !out_valid_q || s.outReady;
  assign accept    = s.inValid && s.inReady;
  assign s_eff     = s.inCorner ? s.inScore : 8'd0;

  // Start of frame overrides the raster position, abandoning any partial frame.
  assign cx      = s.inSof ? '0 : x_q;
  assign cy      = s.inSof ? '0 : y_q;
  assign last_x  = (cx == XW'(WIDTH - 1));
  assign last_y  = (cy == YW'(HEIGHT - 1));
  assign produce = (cx >= XW'(2)) && (cy >= YW'(2));

  assign lb1_rd = line1_q[cx];
  assign lb2_rd = line2_q[cx];

  // Neighbourhood of the window as it will be after this pixel shifts in.
  assign c  = win_q[1][2];
  assign nw = win_q[0][1];
  assign n  = win_q[0][2];
  assign ne = lb2_rd;
  assign w  = win_q[1][1];
  assign e  = lb1_rd;
  assign sw = win_q[2][1];
  assign so = win_q[2][2];
  assign se = s_eff;

`ifdef FS_NMS_TIEBREAK_EN
  assign survive = (c > nw) && (c > n) && (c > ne) && (c > w) &&
                   (c >= e) && (c >= sw) && (c >= so) && (c >= se);
`else
  assign survive = (c >= nw) && (c >= n) && (c >= ne) && (c >= w) &&
                   (c >= e) && (c >= sw) && (c >= so) && (c >= se);
`endif

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    win_d        = win_q;
    out_valid_d  = out_valid_q;
    out_corner_d = out_corner_q;
    out_score_d  = out_score_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    frame_done_d = frame_done_q;
    if (accept) begin
      x_d = last_x ? '0 : cx + XW'(1);
      y_d = last_x ? (last_y ? '0 : cy + YW'(1)) : cy;
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2]  = lb2_rd;
      win_d[1][2]  = lb1_rd;
      win_d[2][2]  = s_eff;
      out_valid_d  = produce;
      frame_done_d = produce && last_x && last_y;
      if (produce) begin
        out_corner_d = (c != 8'd0) && survive;
        out_score_d  = c;
        out_x_d      = cx - XW'(1);
        out_y_d      = cy - YW'(1);
      end
    end else if (s.outReady) begin
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q          <= '0;
      y_q          <= '0;
      win_q        <= '{default: '0};
      out_valid_q  <= 1'b0;
      out_corner_q <= 1'b0;
      out_score_q  <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      win_q        <= win_d;
      out_valid_q  <= out_valid_d;
      out_corner_q <= out_corner_d;
      out_score_q  <= out_score_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffers are pure storage; every row is rewritten before it is read for a result.
  always_ff @(posedge clk) begin
    if (accept) begin
      line2_q[cx] <= lb1_rd;
      line1_q[cx] <= s_eff;
    end
  end

  assign s.outValid  = out_valid_q;
  assign s.outCorner = out_corner_q;
  assign s.outScore  = out_score_q;
  assign s.outX      = out_x_q;
  assign s.outY      = out_y_q;
  assign s.frameDone = frame_done_q;

endmodule

// File: tb/tb_fs_nms.sv
// tb/tb_fs_nms.sv - directed bench for fs_nms on an 8x6 image
module tb_fs_nms;
  localparam int W = 8;
  localparam int H = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fs_nms_if #(.XW(3), .YW(3)) bus ();
  fs_nms #(.WIDTH(W), .HEIGHT(H)) dut (.clk(clk), .rst_n(rst_n), .s(bus));

  int checks = 0;
  int failures = 0;
  int timeouts = 0;
  int img [W*H];

  int epoch = 0;
  int seen_epoch = 0;
  int n_res, n_corner, n_done, bad_done, n_nzscore;
  int res_cnt [W][H];
  int res_score [W][H];
  int res_corner [W][H];

  always @(negedge clk) begin
    if (epoch != seen_epoch) begin
      seen_epoch = epoch;
      n_res = 0; n_corner = 0; n_done = 0; bad_done = 0; n_nzscore = 0;
      for (int i = 0; i < W; i++)
        for (int j = 0; j < H; j++) begin
          res_cnt[i][j] = 0; res_score[i][j] = -1; res_corner[i][j] = -1;
        end
    end else if (rst_n && bus.outValid && bus.outReady) begin
      n_res++;
      if (bus.outCorner) n_corner++;
      if (bus.outScore != 0) n_nzscore++;
      if (bus.frameDone) begin
        n_done++;
        if (bus.outX != 3'd6 || bus.outY != 3'd4) bad_done++;
      end
      if (int'(bus.outY) < H) begin
        res_cnt[bus.outX][bus.outY]++;
        res_score[bus.outX][bus.outY]  = int'(bus.outScore);
        res_corner[bus.outX][bus.outY] = int'(bus.outCorner);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    checks++;
    assert (got === 32'(exp)) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_img();
    for (int i = 0; i < W*H; i++) img[i] = 0;
  endtask

  task automatic new_epoch();
    epoch++;
    @(negedge clk);
  endtask

  task automatic send_pix(input bit sof, input int score, input bit corner);
    int t;
    bus.inValid = 1'b1; bus.inSof = sof; bus.inCorner = corner; bus.inScore = 8'(score);
    t = 0;
    @(negedge clk);
    while (!bus.inReady && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (t >= 100) timeouts++;
    @(posedge clk); #1;
    bus.inValid = 1'b0; bus.inSof = 1'b0;
  endtask

  task automatic do_stall();
    logic [2:0] sx, sy;
    logic [7:0] ss;
    bus.inValid = 1'b1; bus.inSof = 1'b0; bus.inCorner = 1'b0; bus.inScore = 8'hFF;
    bus.outReady = 1'b0;
    @(negedge clk);
    sx = bus.outX; sy = bus.outY; ss = bus.outScore;
    chk("stall_valid0", bus.outValid, 1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_inReady", bus.inReady, 0);
      chk("stall_outX", bus.outX, int'(sx));
      chk("stall_outY", bus.outY, int'(sy));
      chk("stall_score", bus.outScore, int'(ss));
    end
    @(posedge clk); #1;
    bus.outReady = 1'b1;
  endtask

  task automatic send_frame(input int npix, input int stall_at);
    for (int i = 0; i < npix; i++) begin
      if (i == stall_at) do_stall();
      if (img[i] != 0) send_pix(i == 0, img[i], 1'b1);
      else             send_pix(i == 0, (i*37 + 11) & 255, 1'b0);
    end
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_coverage(input string tag);
    int bad;
    bad = 0;
    for (int x = 1; x <= W-2; x++)
      for (int y = 1; y <= H-2; y++)
        if (res_cnt[x][y] != 1) bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    bus.inValid = 1'b0; bus.inSof = 1'b0; bus.inCorner = 1'b0; bus.inScore = '0;
    bus.outReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_outValid", bus.outValid, 0);
    chk("rst_inReady", bus.inReady, 1);
    chk("rst_outCorner", bus.outCorner, 0);
    chk("rst_outScore", bus.outScore, 0);
    chk("rst_outX", bus.outX, 0);
    chk("rst_outY", bus.outY, 0);
    chk("rst_frameDone", bus.frameDone, 0);

    // all-zero frame, garbage scores on non-corner pixels
    clr_img(); new_epoch(); send_frame(W*H, -1); drain();
    chk("zero_nres", n_res, 24);
    chk("zero_ncorner", n_corner, 0);
    chk("zero_nzscore", n_nzscore, 0);
    chk("zero_ndone", n_done, 1);
    chk("zero_baddone", bad_done, 0);
    check_coverage("zero_cover");

    // isolated corners, one on the border
    clr_img(); img[2*W+3] = 50; img[0] = 90;
    new_epoch(); send_frame(W*H, -1); drain();
    chk("iso_ncorner", n_corner, 1);
    chk("iso_corner32", res_corner[3][2], 1);
    chk("iso_score32", res_score[3][2], 50);
    chk("iso_corner11", res_corner[1][1], 0);

    // suppression
    clr_img(); img[2*W+3] = 50; img[2*W+4] = 60;
    new_epoch(); send_frame(W*H, -1); drain();
    chk("sup_ncorner", n_corner, 1);
    chk("sup_corner42", res_corner[4][2], 1);
    chk("sup_corner32", res_corner[3][2], 0);
    chk("sup_score32", res_score[3][2], 50);
    chk("sup_score42", res_score[4][2], 60);

    // ties
    clr_img(); img[2*W+3] = 40; img[2*W+4] = 40;
    new_epoch(); send_frame(W*H, -1); drain();
    chk("tie_corner32", res_corner[3][2], 1);
`ifdef FS_NMS_TIEBREAK_EN
    chk("tie_ncorner", n_corner, 1);
    chk("tie_corner42", res_corner[4][2], 0);
`else
    chk("tie_ncorner", n_corner, 2);
    chk("tie_corner42", res_corner[4][2], 1);
`endif

    // backpressure mid-frame
    clr_img(); img[2*W+3] = 33;
    new_epoch(); send_frame(W*H, 21); drain();
    chk("bp_nres", n_res, 24);
    chk("bp_ndone", n_done, 1);
    chk("bp_corner32", res_corner[3][2], 1);
    check_coverage("bp_cover");

    // restart: inSof at pixel 20 abandons the partial frame
    clr_img(); img[2*W+3] = 77;
    new_epoch(); send_frame(20, -1); send_frame(W*H, -1); drain();
    chk("rs_nres", n_res, 26);
    chk("rs_ndone", n_done, 1);
    chk("rs_baddone", bad_done, 0);
    chk("rs_ncorner", n_corner, 1);
    chk("rs_score32", res_score[3][2], 77);

    // reset mid-stream with a live result on the output
    clr_img(); img[2*W+4] = 50;
    new_epoch(); send_frame(30, -1);
    chk("mr_pre_valid", bus.outValid, 1);
    chk("mr_pre_score", bus.outScore, 50);
    chk("mr_pre_corner", bus.outCorner, 1);
    chk("mr_pre_x", bus.outX, 4);
    rst_n = 1'b0;
    #1;
    chk("mr_outValid", bus.outValid, 0);
    chk("mr_outScore", bus.outScore, 0);
    chk("mr_outCorner", bus.outCorner, 0);
    chk("mr_outX", bus.outX, 0);
    chk("mr_outY", bus.outY, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mr_inReady", bus.inReady, 1);
    clr_img();
    new_epoch(); send_frame(W*H, -1); drain();
    chk("mr_nres", n_res, 24);
    chk("mr_ndone", n_done, 1);
    chk("mr_ncorner", n_corner, 0);
    check_coverage("mr_cover");

    chk("timeouts", timeouts, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
